fdiv_mul: RTL and testbench

//  Back end of the single-precision divider: q = x / y computed as x * finv(y).
//  The caller presents x and y together; y goes to finv, y_inv comes back.

---
 rtl/fdiv_mul.sv | 155 +++++++++++++++
 tb/tb_fdiv_mul.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_mul.sv
// Back end of the single-precision divider: q = x * finv(y), truncating.
// x and the y special-case flags ride a delay line to meet y_inv, then a 2-stage multiply.
module fdiv_mul #(
   parameter int unsigned FINV_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [31:0] y_inv,
   output logic        out_valid,
   output logic [31:0] q,
   output logic        dbz
);

   // d[0] captures with finv's sample of y; d[DEPTH-1] is stable alongside y_inv
   localparam int unsigned DEPTH = FINV_LAT + 1;
   localparam int unsigned MW    = 24;
   localparam int unsigned PW    = 2 * MW;
   localparam int unsigned KW    = PW - 23;
   localparam int unsigned EW    = 10;

   typedef struct packed {
      logic [31:0] x;
      logic        ss;
      logic        yz;
      logic        yi;
   } dl_t;

   logic [DEPTH-1:0] dv;
   dl_t              dd [DEPTH];
   dl_t              tail;

   logic          sp_c;
   logic          spdbz_c;
   logic [31:0]   spq_c;
   logic [PW-1:0] p_c;
   logic          unused_lo;

   logic                 m1_v;
   logic                 m1_sp;
   logic                 m1_dbz;
   logic [31:0]          m1_spq;
   logic                 m1_s;
   logic [KW-1:0]        m1_p;
   logic signed [EW-1:0] m1_es;

   logic signed [EW-1:0] e_c;
   logic [22:0]          m_c;
   logic [31:0]          res_c;

   // Valid bits are the only delay-line state that needs reset
   always_ff @(posedge clk) begin
      if (rst) begin
         dv <= '0;
      end else begin
         dv <= {dv[DEPTH-2:0], in_valid};
      end
   end

   always_ff @(posedge clk) begin
      dd[0] <= '{x:  x,
                 ss: x[31] ^ y[31],
                 yz: (y[30:23] == 8'h00),
                 yi: (y[30:23] == 8'hFF)};
      for (int i = 1; i < int'(DEPTH); i++) begin
         dd[i] <= dd[i-1];
      end
   end

   assign tail = dd[DEPTH-1];

   // Special-case selection in priority order; denormal y already folded into yz
   always_comb begin
      sp_c    = 1'b0;
      spdbz_c = 1'b0;
      spq_c   = '0;
      if (tail.yz) begin
         sp_c    = 1'b1;
         spdbz_c = 1'b1;
         spq_c   = {tail.ss, 8'hFF, 23'h0};
      end else if (tail.yi) begin
         sp_c  = 1'b1;
         spq_c = {tail.ss, 31'h0};
      end else if (tail.x[30:23] == 8'hFF) begin
         sp_c  = 1'b1;
         spq_c = {tail.ss, 8'hFF, 23'h0};
      end else if (tail.x[30:23] == 8'h00) begin
         sp_c  = 1'b1;
         spq_c = {tail.ss, 31'h0};
      end
   end

   assign p_c = PW'({1'b1, tail.x[22:0]}) * PW'({1'b1, y_inv[22:0]});

   // Mantissa bits below the truncation point and y's fraction never matter
   assign unused_lo = ^{y[22:0], p_c[22:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         m1_v <= 1'b0;
      end else begin
         m1_v <= dv[DEPTH-1];
      end
   end

   always_ff @(posedge clk) begin
      m1_sp  <= sp_c;
      m1_dbz <= spdbz_c;
      m1_spq <= spq_c;
      m1_s   <= tail.x[31] ^ y_inv[31];
      m1_p   <= p_c[PW-1:23];
      m1_es  <= EW'(tail.x[30:23]) + EW'(y_inv[30:23]);
   end

   // Normalise the product and clamp the exponent; no denormal outputs
   always_comb begin
      e_c   = '0;
      m_c   = '0;
      res_c = '0;
      if (m1_p[KW-1]) begin
         e_c = m1_es - 10'sd126;
         m_c = m1_p[KW-2:1];
      end else begin
         e_c = m1_es - 10'sd127;
         m_c = m1_p[KW-3:0];
      end
      if (m1_sp) begin
         res_c = m1_spq;
      end else if (e_c <= 10'sd0) begin
         res_c = {m1_s, 31'h0};
      end else if (e_c >= 10'sd255) begin
         res_c = {m1_s, 8'hFF, 23'h0};
      end else begin
         res_c = {m1_s, e_c[7:0], m_c};
      end
   end

   // q/dbz hold between valid results
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         q         <= 32'h0;
         dbz       <= 1'b0;
      end else begin
         out_valid <= m1_v;
         if (m1_v) begin
            q   <= res_c;
            dbz <= m1_dbz;
         end
      end
   end

endmodule

// File: tb/tb_fdiv_mul.sv
// Directed bench for fdiv_mul: a 4-register stand-in for finv feeds y_inv,
// and a per-cycle scoreboard checks out_valid, q and dbz after every edge.
module tb_fdiv_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] x;
   logic [31:0] y;
   logic [31:0] y_inv;
   logic        out_valid;
   logic [31:0] q;
   logic        dbz;

   logic [31:0] yinv_src;
   logic [31:0] f0, f1, f2, f3;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic        ev  [0:511];
   logic [31:0] eqa [0:511];
   logic        eda [0:511];
   logic [31:0] lq;
   logic        ld;

   logic [31:0] vx [0:7];
   logic [31:0] vy [0:7];
   logic [31:0] vi [0:7];
   logic [31:0] vq [0:7];
   logic        vd [0:7];

   fdiv_mul #(.FINV_LAT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .y         (y),
      .y_inv     (y_inv),
      .out_valid (out_valid),
      .q         (q),
      .dbz       (dbz)
   );

   always #5 clk = ~clk;

   // finv stand-in: y sampled at edge 0, y_inv stable after edge 3
   always @(posedge clk) begin
      f0 <= yinv_src;
      f1 <= f0;
      f2 <= f1;
      f3 <= f2;
   end
   assign y_inv = f3;

   task automatic chk1(input string tag, input logic act, input logic exp);
      n_chk++;
      assert (act === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      assert (act === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (ev[cyc]) begin
         lq = eqa[cyc];
         ld = eda[cyc];
      end
      chk1("out_valid", out_valid, ev[cyc]);
      chk32("q", q, lq);
      chk1("dbz", dbz, ld);
   endtask

   // Inputs set now are sampled at edge cyc+1; the result appears after edge cyc+6
   task automatic issue(input logic [31:0] xi, input logic [31:0] yi,
                        input logic [31:0] yv, input logic [31:0] eq,
                        input logic ed);
      in_valid = 1'b1;
      x        = xi;
      y        = yi;
      yinv_src = yv;
      ev[cyc+6]  = 1'b1;
      eqa[cyc+6] = eq;
      eda[cyc+6] = ed;
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b0;
         x        = 32'h5A5A_1234;
         y        = 32'h0000_0000;
         yinv_src = 32'hA5A5_4321;
         tick();
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst      = 1'b1;
      for (int i = cyc + 1; i < 512; i++) ev[i] = 1'b0;
      lq = 32'h0;
      ld = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         ev[i]  = 1'b0;
         eqa[i] = 32'h0;
         eda[i] = 1'b0;
      end
      lq       = 32'h0;
      ld       = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      x        = 32'h0;
      y        = 32'h0;
      yinv_src = 32'h0;

      // reset state
      tick();
      tick();
      rst = 1'b0;
      idle(2);

      // 1.0 / 1.0
      issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
      idle(6);

      // 6/2 and -6/2, back to back
      issue(32'h40C0_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, 1'b0);
      issue(32'hC0C0_0000, 32'h4000_0000, 32'h3F00_0000, 32'hC040_0000, 1'b0);
      // zero and denormal divisors, 0/0
      issue(32'h40C0_0000, 32'h0000_0000, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
      issue(32'h40C0_0000, 32'h8000_0001, 32'h1234_5678, 32'hFF80_0000, 1'b1);
      issue(32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1);
      // infinite divisor, both signs
      issue(32'h40C0_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0);
      issue(32'h40C0_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0);
      // infinite / NaN-pattern x, zero and denormal x
      issue(32'h7F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b0);
      issue(32'h7FC0_0000, 32'h4000_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b0);
      issue(32'h8000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h8000_0000, 1'b0);
      issue(32'h0000_0001, 32'h4000_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0);
      // underflow flush and overflow to inf
      issue(32'h0080_0000, 32'h4000_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0);
      issue(32'h7F00_0000, 32'h3F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0);
      // product carries into bit 47: 1.5 * 1.5
      issue(32'h3FC0_0000, 32'h3F2A_AAAB, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
      // normal-path sign from y_inv
      issue(32'h40C0_0000, 32'hC000_0000, 32'hBF00_0000, 32'hC040_0000, 1'b0);
      // truncation of low product bits
      issue(32'h3F80_0001, 32'h3F7F_FFFE, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
      idle(6);

      // 8-op stream, then ops separated by 1-2 cycle bubbles
      vx[0] = 32'h3F80_0000; vy[0] = 32'h3F80_0000; vi[0] = 32'h3F80_0000; vq[0] = 32'h3F80_0000; vd[0] = 1'b0;
      vx[1] = 32'h40C0_0000; vy[1] = 32'h4000_0000; vi[1] = 32'h3F00_0000; vq[1] = 32'h4040_0000; vd[1] = 1'b0;
      vx[2] = 32'h40C0_0000; vy[2] = 32'h0000_0000; vi[2] = 32'hFFFF_FFFF; vq[2] = 32'h7F80_0000; vd[2] = 1'b1;
      vx[3] = 32'h3FC0_0000; vy[3] = 32'h3F2A_AAAB; vi[3] = 32'h3FC0_0000; vq[3] = 32'h4010_0000; vd[3] = 1'b0;
      vx[4] = 32'hC0C0_0000; vy[4] = 32'h4000_0000; vi[4] = 32'h3F00_0000; vq[4] = 32'hC040_0000; vd[4] = 1'b0;
      vx[5] = 32'h0080_0000; vy[5] = 32'h4000_0000; vi[5] = 32'h3F00_0000; vq[5] = 32'h0000_0000; vd[5] = 1'b0;
      vx[6] = 32'h7F00_0000; vy[6] = 32'h3F00_0000; vi[6] = 32'h4000_0000; vq[6] = 32'h7F80_0000; vd[6] = 1'b0;
      vx[7] = 32'h3F80_0001; vy[7] = 32'h3F7F_FFFE; vi[7] = 32'h3F80_0001; vq[7] = 32'h3F80_0002; vd[7] = 1'b0;
      for (int i = 0; i < 8; i++) issue(vx[i], vy[i], vi[i], vq[i], vd[i]);
      issue(vx[2], vy[2], vi[2], vq[2], vd[2]);
      idle(1);
      issue(vx[1], vy[1], vi[1], vq[1], vd[1]);
      idle(2);
      issue(vx[4], vy[4], vi[4], vq[4], vd[4]);
      idle(1);
      issue(vx[3], vy[3], vi[3], vq[3], vd[3]);
      idle(7);

      // reset with two ops in flight; op issued two edges later still comes out
      issue(vx[0], vy[0], vi[0], vq[0], vd[0]);
      issue(vx[2], vy[2], vi[2], vq[2], vd[2]);
      do_reset();
      idle(1);
      issue(vx[4], vy[4], vi[4], vq[4], vd[4]);
      idle(7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
